// File: rtl/sntc_ldpc_pkg.sv
// rtl/sntc_ldpc_pkg.sv - shared LDPC H-matrix tables, sizes and FSM state type
package sntc_ldpc_pkg;
  localparam int MM       = 'h000a8;
  localparam int NN       = 'h000d0;
  localparam int CMAX     = 'h00017;
  localparam int RMAX     = 'h0000a;
  localparam int KK       = NN - MM;
  localparam int UPC_W    = $clog2(CMAX + 1);
  localparam int IDX_NONE = -1;
  localparam int BAND     = 56;
  localparam int P0_MID   = 84;

  typedef enum logic [1:0] {ST_IDLE, ST_SYN, ST_FLIP, ST_DONE} state_t;

  // Parity part is dual-diagonal closed by a weight-3 column 0; message columns hit
  // one row in each 56-row band. No two columns share more than one check.
  function automatic int col_weight(input int j);
    return (j == 0 || j >= MM) ? 3 : 2;
  endfunction

  function automatic int col_row(input int j, input int n);
    int k;
    if (n >= col_weight(j)) return IDX_NONE;
    if (j >= MM) begin
      k = j - MM;
      if (n == 0) return k;
      if (n == 1) return BAND + (2 * k) % BAND;
      return 2 * BAND + (5 * k) % BAND;
    end
    if (j == 0) return (n == 0) ? 0 : ((n == 1) ? P0_MID : MM - 1);
    return j - 1 + n;
  endfunction

  function automatic int row_col(input int i, input int n);
    int hit;
    hit = 0;
    for (int j = 0; j < NN; j++)
      for (int m = 0; m < CMAX; m++)
        if (col_row(j, m) == i) begin
          if (hit == n && n < RMAX) return j;
          hit++;
        end
    return IDX_NONE;
  endfunction

  function automatic logic [MM-1:0] col_mask(input int j);
    logic [MM-1:0] m;
    int r;
    m = '0;
    for (int n = 0; n < CMAX; n++) begin
      r = col_row(j, n);
      if (r != IDX_NONE) m[8'(r)] = 1'b1;
    end
    return m;
  endfunction
endpackage

// File: rtl/sntc_ldpc_bf_flip_unit.sv
// rtl/sntc_ldpc_bf_flip_unit.sv - per-bit unsatisfied-check counts, max search and bit flip
module sntc_ldpc_bf_flip_unit
  import sntc_ldpc_pkg::*;
(
  input  logic [MM-1:0]    i_syn,
  input  logic [NN-1:0]    i_word,
  output logic [NN-1:0]    o_word_nxt,
  output logic [UPC_W-1:0] o_upc_max
);
  logic [NN-1:0][UPC_W-1:0] w_upc;

  for (genvar j = 0; j < NN; j++) begin : g_col
    localparam logic [MM-1:0] COL_MASK = col_mask(j);
    assign w_upc[j]      = UPC_W'($countones(i_syn & COL_MASK));
    assign o_word_nxt[j] = i_word[j] ^ (w_upc[j] == o_upc_max);
  end

  always_comb begin
    o_upc_max = '0;
    for (int j = 0; j < NN; j++)
      if (w_upc[j] > o_upc_max) o_upc_max = w_upc[j];
  end
endmodule

// File: rtl/sntc_ldpc_bf_decoder_wrapper.sv
// rtl/sntc_ldpc_bf_decoder_wrapper.sv - hard-decision bit-flipping LDPC decoder with handshake
module sntc_ldpc_bf_decoder_wrapper
  import sntc_ldpc_pkg::*;
#(
  parameter  int MAX_ITER = 16,
  localparam int ITER_W   = (MAX_ITER > 0) ? $clog2(MAX_ITER + 1) : 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NN-1:0]     y_nr_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [NN-1:0]     y_nr,
  output logic [NN-MM-1:0]  msg_out,
  output logic              valid_cword,
  output logic              dec_fail,
  output logic [ITER_W-1:0] iter_cnt
);
  state_t            r_state, w_state_nxt;
  logic [NN-1:0]     r_word, w_word_flip, r_y_nr;
  logic [MM-1:0]     r_syn, w_syn;
  logic [ITER_W-1:0] r_iter, r_iter_cnt;
  logic              r_valid_cword, r_dec_fail;
  logic [UPC_W-1:0]  w_upc_max;
  logic              w_accept, w_clean, w_exhausted;
  logic [NN-1:0][MM-1:0] w_col_term;

  for (genvar j = 0; j < NN; j++) begin : g_syn
    localparam logic [MM-1:0] COL_MASK = col_mask(j);
    assign w_col_term[j] = r_word[j] ? COL_MASK : '0;
  end

  always_comb begin
    w_syn = '0;
    for (int j = 0; j < NN; j++) w_syn = w_syn ^ w_col_term[j];
  end

  sntc_ldpc_bf_flip_unit u_flip (
    .i_syn      (r_syn),
    .i_word     (r_word),
    .o_word_nxt (w_word_flip),
    .o_upc_max  (w_upc_max)
  );

  // Every row has at least one column, so a zero UPC maximum means a zero syndrome.
  assign w_clean     = (w_upc_max == '0);
  assign w_exhausted = (r_iter == ITER_W'(MAX_ITER));
  assign w_accept    = in_ready && in_valid;

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = ST_SYN;
      end
      ST_SYN:  w_state_nxt = ST_FLIP;
      ST_FLIP: w_state_nxt = (w_clean || w_exhausted) ? ST_DONE : ST_SYN;
      ST_DONE: begin
        in_ready = out_ready;
        if (out_ready) w_state_nxt = in_valid ? ST_SYN : ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= ST_IDLE;
      r_word        <= '0;
      r_syn         <= '0;
      r_iter        <= '0;
      r_y_nr        <= '0;
      r_valid_cword <= 1'b0;
      r_dec_fail    <= 1'b0;
      r_iter_cnt    <= '0;
    end else if (clr) begin
      r_state       <= ST_IDLE;
      r_word        <= '0;
      r_syn         <= '0;
      r_iter        <= '0;
      r_y_nr        <= '0;
      r_valid_cword <= 1'b0;
      r_dec_fail    <= 1'b0;
      r_iter_cnt    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_word <= y_nr_in;
        r_iter <= '0;
      end
      if (r_state == ST_SYN) r_syn <= w_syn;
      if (r_state == ST_FLIP) begin
        if (w_clean || w_exhausted) begin
          r_y_nr        <= r_word;
          r_valid_cword <= w_clean;
          r_dec_fail    <= !w_clean;
          r_iter_cnt    <= r_iter;
        end else begin
          r_word <= w_word_flip;
          r_iter <= r_iter + ITER_W'(1);
        end
      end
    end
  end

  assign out_valid   = (r_state == ST_DONE);
  assign y_nr        = r_y_nr;
  assign msg_out     = r_y_nr[NN-1:MM];
  assign valid_cword = r_valid_cword;
  assign dec_fail    = r_dec_fail;
  assign iter_cnt    = r_iter_cnt;
endmodule

// File: doc/sntc_ldpc_bf_decoder_wrapper.md
Name: sntc_ldpc_bf_decoder_wrapper

Overview:
- Hard-decision bit-flipping LDPC decoder; receive-side counterpart of sntc_ldpc_encoder_wrapper.
- Accepts one NN-bit received word per handshake and iterates syndrome-compute / bit-flip until the syndrome is zero or MAX_ITER is reached.
- Returns the corrected codeword, its systematic message bits y_nr[NN-1:MM], and status.
- Uses the same parity-check matrix as the encoder and syndrome wrappers.

Parameters:
- MM, 'h000a8: number of parity checks (H rows) = number of parity bits.
- NN, 'h000d0: codeword length (H columns).
- cmax, 'h00017: maximum column weight; sets the unsatisfied-parity-count (UPC) width.
- rmax, 'h0000a: maximum row weight.
- MAX_ITER, 16: maximum flip iterations before declaring failure; 0 is legal.
- ITER_W, $clog2(MAX_ITER+1): iteration counter width.
- UPC_W, $clog2(cmax+1): per-bit UPC width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- clr  in  1  synchronous abort/clear; highest priority after rstn.
- in_valid  in  1  received word present.
- in_ready  out  1  decoder can accept a word.
- y_nr_in  in  NN  received hard-decision word; [NN-1:MM] message, [MM-1:0] parity.
- out_valid  out  1  decode result present.
- out_ready  in  1  consumer accepts the result.
- y_nr  out  NN  corrected codeword.
- msg_out  out  NN-MM  y_nr[NN-1:MM].
- valid_cword  out  1  final syndrome is zero.
- dec_fail  out  1  MAX_ITER exhausted with nonzero syndrome.
- iter_cnt  out  ITER_W  flip iterations performed.

Behaviour:
- Reset (rstn=0, async): state IDLE; in_ready=1 (derived from state); every other output 0; internal word, syndrome and counter cleared.
- clr=1 at an edge: same result as reset, synchronously. Overrides any handshake in that cycle; an in-flight word is discarded and no out_valid is produced for it.
- FSM states: IDLE, SYN, FLIP, DONE.
  - IDLE: in_ready=1. On in_valid: load y_nr_in into word_r, clear iter_r, go to SYN.
  - SYN: register syn_r = H·word_r over GF(2) (MM bits).
  - SYN exit: if syn_r==0, go to DONE with valid_cword=1, dec_fail=0.
  - SYN exit: else if iter_r==MAX_ITER, go to DONE with valid_cword=0, dec_fail=1.
  - SYN exit: else go to FLIP.
  - FLIP: for each bit j, upc[j] = number of unsatisfied checks in column j (UPC_W bits, saturation not needed).
  - FLIP: upc_max = maximum over all j. Flip every bit with upc[j]==upc_max. upc_max>0 is guaranteed because syn_r is nonzero.
  - FLIP: iter_r+1, then back to SYN.
  - DONE: out_valid=1. y_nr, msg_out, valid_cword, dec_fail and iter_cnt are held stable until out_ready.
  - DONE exit: on out_ready, out_valid drops next cycle and state returns to IDLE.
  - DONE: in_ready = out_ready. A new word may be accepted in the same cycle the result is consumed; state then goes directly to SYN.
- Latency:
  - Accept at edge T.
  - Syndrome registered at T+1.
  - out_valid at T+2 for a clean word.
  - Each flip iteration adds 2 cycles; total latency 2+2·iter_cnt.
- Output registers are updated only on entry to DONE; they are not recomputed while held.
- in_valid is ignored outside IDLE and outside DONE-with-out_ready. No buffering.
- Syndrome and UPC logic is combinational from the H-matrix package tables. No multi-cycle paths.

Decomposition:
- Shared package sntc_ldpc_pkg:
  - H row-to-column index table [MM][rmax].
  - Column-to-row index table [NN][cmax], with an invalid marker for short columns.
  - Column weight table [NN].
  - NN/MM/cmax/rmax constants.
  - FSM state typedef.
- The encoder and syndrome wrappers consume the same package.
- Sub-module sntc_ldpc_bf_flip_unit (combinational):
  - Inputs: syn_r, word_r.
  - Outputs: next word and upc_max.
  - Contains the per-bit UPC adders and the max-reduction tree.
- The wrapper holds the FSM, counter, syndrome register and handshake.

Test Plan:
- All-zero y_nr_in, out_ready=1 -> out_valid exactly 2 cycles after accept; y_nr=0, valid_cword=1, dec_fail=0, iter_cnt=0.
- Message 40'h1 encoded by sntc_ldpc_encoder_wrapper, bit 5 inverted -> y_nr equals the encoded word, msg_out=40'h1, iter_cnt=1, out_valid 4 cycles after accept.
- MAX_ITER=0, all-zero word with bit 200 set -> dec_fail=1, valid_cword=0, iter_cnt=0, y_nr unchanged (bit 200 still set).
- out_ready low for 5 cycles in DONE -> out_valid and all outputs stable, in_ready=0. Then out_ready=1 with in_valid=1 -> second word accepted that same edge; its out_valid arrives 2 cycles later.
- Within 1 cycle of accepting an erroneous word (state SYN): first run asserts clr -> next cycle IDLE, in_ready=1, outputs 0, and no out_valid ever for that word. Second run deasserts rstn asynchronously mid-FLIP -> outputs zero immediately, without waiting for a clock edge.
- Back-to-back stream of 20 random codewords, each with 0-2 random bit errors, out_ready randomly toggled -> every result matches the scoreboard in order, with no lost or duplicated words.
